// File: rtl/pong_pkg.sv
// Shared grid geometry, FSM encoding and paddle helpers for the Pong game engine.
package pong_pkg;

  localparam logic [3:0] ROWS    = 4'd15;
  localparam logic [3:0] ROW_MAX = ROWS - 4'd1;
  localparam logic [4:0] COM_COL = 5'd14;
  localparam logic [3:0] PAD_LEN = 4'd5;
  localparam logic [3:0] PAD_MAX = 4'd10;
  localparam logic [3:0] CENTER  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  // Row the computer paddle steers its top edge toward so the ball sits mid-paddle.
  function automatic logic [3:0] com_target(input logic [3:0] ball_y);
    logic [3:0] tgt;
    if (ball_y < 4'd2) begin
      tgt = 4'd0;
    end else if ((ball_y - 4'd2) > PAD_MAX) begin
      tgt = PAD_MAX;
    end else begin
      tgt = ball_y - 4'd2;
    end
    return tgt;
  endfunction

  function automatic logic pad_covers(input logic [3:0] pos, input logic [3:0] row);
    return (row >= pos) && (row <= (pos + PAD_LEN - 4'd1));
  endfunction

endpackage

// File: rtl/pong_btn_sync.sv
// Two-flop synchronizer for an asynchronous button; optionally emits a one-cycle
// pulse on the synchronized rising edge instead of the level.
module pong_btn_sync #(
  parameter bit EDGE_OUT = 1'b0
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic btn,
  output logic q
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign q = EDGE_OUT ? (sync_r & ~prev_r) : sync_r;

endmodule

// File: rtl/pong_game_engine.sv
// Pong game-state engine: ball, paddles, scores and round sequencing on a 15x15 grid.
// Advances on FRAME_TICK; every output comes straight from a register.
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int BALL_DIV     = 4,
  parameter int PAD_DIV      = 2,
  parameter int PAUSE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  input  logic       FRAME_TICK,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_START,
  output logic [4:0] ballX,
  output logic [3:0] ballY,
  output logic [3:0] playerPos,
  output logic [3:0] comPos,
  output logic [3:0] playerScore,
  output logic [3:0] comScore,
  output logic [1:0] state
);

  localparam int BALL_CW  = $clog2(BALL_DIV + 1);
  localparam int PAD_CW   = $clog2(PAD_DIV + 1);
  localparam int PAUSE_CW = $clog2(PAUSE_FRAMES + 1);

  localparam logic [BALL_CW-1:0]  BALL_LAST  = BALL_CW'(BALL_DIV - 1);
  localparam logic [BALL_CW-1:0]  BALL_ONE   = BALL_CW'(1);
  localparam logic [BALL_CW-1:0]  BALL_ZERO  = BALL_CW'(0);
  localparam logic [PAD_CW-1:0]   PAD_LAST   = PAD_CW'(PAD_DIV - 1);
  localparam logic [PAD_CW-1:0]   PAD_ONE    = PAD_CW'(1);
  localparam logic [PAD_CW-1:0]   PAD_ZERO   = PAD_CW'(0);
  localparam logic [PAUSE_CW-1:0] PAUSE_LAST = PAUSE_CW'(PAUSE_FRAMES - 1);
  localparam logic [PAUSE_CW-1:0] PAUSE_ONE  = PAUSE_CW'(1);
  localparam logic [PAUSE_CW-1:0] PAUSE_ZERO = PAUSE_CW'(0);
  localparam logic [3:0]          WIN_L      = 4'(WIN_SCORE);

  game_state_e state_r, state_nxt_s;
  logic [4:0] ball_x_r, ball_x_nxt_s;
  logic [3:0] ball_y_r, ball_y_nxt_s;
  logic       dx_r, dx_nxt_s;   // 1: moving right
  logic       dy_r, dy_nxt_s;   // 1: moving down
  logic [3:0] player_pos_r, player_pos_nxt_s;
  logic [3:0] com_pos_r, com_pos_nxt_s;
  logic [3:0] player_score_r, player_score_nxt_s;
  logic [3:0] com_score_r, com_score_nxt_s;
  logic [BALL_CW-1:0]  ball_cnt_r, ball_cnt_nxt_s;
  logic [PAD_CW-1:0]   pad_cnt_r, pad_cnt_nxt_s;
  logic [PAUSE_CW-1:0] pause_cnt_r, pause_cnt_nxt_s;

  logic       btn_up_s, btn_dn_s, start_s;
  logic       ball_due_s, pad_due_s;
  logic       step_dy_s, step_dx_s;
  logic [3:0] step_y_s;
  logic [4:0] step_x_s;
  logic       com_pt_s, ply_pt_s;
  logic [3:0] ply_step_s, com_step_s, com_tgt_s;
  logic [3:0] com_inc_s, ply_inc_s;

  pong_btn_sync #(.EDGE_OUT(1'b0)) u_sync_up (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .btn(BTN_UP), .q(btn_up_s)
  );
  pong_btn_sync #(.EDGE_OUT(1'b0)) u_sync_down (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .btn(BTN_DOWN), .q(btn_dn_s)
  );
  pong_btn_sync #(.EDGE_OUT(1'b1)) u_sync_start (
    .CLK_IN(CLK_IN), .RST_N(RST_N), .btn(BTN_START), .q(start_s)
  );

  assign ball_due_s = (ball_cnt_r == BALL_LAST);
  assign pad_due_s  = (pad_cnt_r == PAD_LAST);
  assign com_inc_s  = com_score_r + 4'd1;
  assign ply_inc_s  = player_score_r + 4'd1;

  // Candidate ball move: reflect off top/bottom first, then resolve paddle or gutter
  always_comb begin
    if ((ball_y_r == 4'd0) && !dy_r) begin
      step_dy_s = 1'b1;
    end else if ((ball_y_r == ROW_MAX) && dy_r) begin
      step_dy_s = 1'b0;
    end else begin
      step_dy_s = dy_r;
    end
    step_y_s  = step_dy_s ? (ball_y_r + 4'd1) : (ball_y_r - 4'd1);
    step_x_s  = ball_x_r;
    step_dx_s = dx_r;
    com_pt_s  = 1'b0;
    ply_pt_s  = 1'b0;
    if ((ball_x_r == 5'd1) && !dx_r) begin
      if (pad_covers(player_pos_r, step_y_s)) begin
        step_dx_s = 1'b1;
        step_x_s  = 5'd2;
      end else begin
        step_x_s = 5'd0;
        com_pt_s = 1'b1;
      end
    end else if ((ball_x_r == (COM_COL - 5'd1)) && dx_r) begin
      if (pad_covers(com_pos_r, step_y_s)) begin
        step_dx_s = 1'b0;
        step_x_s  = COM_COL - 5'd2;
      end else begin
        step_x_s = COM_COL;
        ply_pt_s = 1'b1;
      end
    end else if (dx_r) begin
      step_x_s = ball_x_r + 5'd1;
    end else begin
      step_x_s = ball_x_r - 5'd1;
    end
  end

  // Candidate paddle positions for a paddle step
  always_comb begin
    if (btn_up_s && !btn_dn_s) begin
      ply_step_s = (player_pos_r == 4'd0) ? 4'd0 : (player_pos_r - 4'd1);
    end else if (btn_dn_s && !btn_up_s) begin
      ply_step_s = (player_pos_r == PAD_MAX) ? PAD_MAX : (player_pos_r + 4'd1);
    end else begin
      ply_step_s = player_pos_r;
    end
    com_tgt_s = com_target(ball_y_r);
    if (com_pos_r < com_tgt_s) begin
      com_step_s = com_pos_r + 4'd1;
    end else if (com_pos_r > com_tgt_s) begin
      com_step_s = com_pos_r - 4'd1;
    end else begin
      com_step_s = com_pos_r;
    end
  end

  // Game FSM next state and per-tick register updates
  always_comb begin
    state_nxt_s        = state_r;
    ball_x_nxt_s       = ball_x_r;
    ball_y_nxt_s       = ball_y_r;
    dx_nxt_s           = dx_r;
    dy_nxt_s           = dy_r;
    player_pos_nxt_s   = player_pos_r;
    com_pos_nxt_s      = com_pos_r;
    player_score_nxt_s = player_score_r;
    com_score_nxt_s    = com_score_r;
    ball_cnt_nxt_s     = BALL_ZERO;
    pad_cnt_nxt_s      = PAD_ZERO;
    pause_cnt_nxt_s    = PAUSE_ZERO;
    case (state_r)
      ST_IDLE: begin
        if (FRAME_TICK) begin
          pad_cnt_nxt_s    = pad_due_s ? PAD_ZERO : (pad_cnt_r + PAD_ONE);
          player_pos_nxt_s = pad_due_s ? ply_step_s : player_pos_r;
        end else begin
          pad_cnt_nxt_s = pad_cnt_r;
        end
        if (start_s) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (FRAME_TICK) begin
          pad_cnt_nxt_s    = pad_due_s ? PAD_ZERO : (pad_cnt_r + PAD_ONE);
          player_pos_nxt_s = pad_due_s ? ply_step_s : player_pos_r;
          com_pos_nxt_s    = pad_due_s ? com_step_s : com_pos_r;
          ball_cnt_nxt_s   = ball_due_s ? BALL_ZERO : (ball_cnt_r + BALL_ONE);
        end else begin
          pad_cnt_nxt_s  = pad_cnt_r;
          ball_cnt_nxt_s = ball_cnt_r;
        end
        if (FRAME_TICK && ball_due_s) begin
          ball_x_nxt_s = step_x_s;
          ball_y_nxt_s = step_y_s;
          dx_nxt_s     = step_dx_s;
          dy_nxt_s     = step_dy_s;
          if (com_pt_s) begin
            com_score_nxt_s = com_inc_s;
            state_nxt_s     = (com_inc_s >= WIN_L) ? ST_OVER : ST_POINT;
          end else if (ply_pt_s) begin
            player_score_nxt_s = ply_inc_s;
            state_nxt_s        = (ply_inc_s >= WIN_L) ? ST_OVER : ST_POINT;
          end else begin
            state_nxt_s = ST_PLAY;
          end
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_POINT: begin
        // Serve goes toward whoever just scored: a ball in column 0 means the computer scored.
        if (FRAME_TICK && (pause_cnt_r == PAUSE_LAST)) begin
          state_nxt_s  = ST_IDLE;
          ball_x_nxt_s = {1'b0, CENTER};
          ball_y_nxt_s = CENTER;
          dy_nxt_s     = 1'b1;
          dx_nxt_s     = (ball_x_r == 5'd0);
        end else if (FRAME_TICK) begin
          pause_cnt_nxt_s = pause_cnt_r + PAUSE_ONE;
        end else begin
          pause_cnt_nxt_s = pause_cnt_r;
        end
      end
      ST_OVER: begin
        if (start_s) begin
          state_nxt_s        = ST_IDLE;
          player_score_nxt_s = 4'd0;
          com_score_nxt_s    = 4'd0;
          ball_x_nxt_s       = {1'b0, CENTER};
          ball_y_nxt_s       = CENTER;
          dx_nxt_s           = 1'b1;
        end else begin
          state_nxt_s = ST_OVER;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Game state registers
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_r        <= ST_IDLE;
      ball_x_r       <= {1'b0, CENTER};
      ball_y_r       <= CENTER;
      dx_r           <= 1'b1;
      dy_r           <= 1'b1;
      player_pos_r   <= 4'd5;
      com_pos_r      <= 4'd5;
      player_score_r <= 4'd0;
      com_score_r    <= 4'd0;
      ball_cnt_r     <= BALL_ZERO;
      pad_cnt_r      <= PAD_ZERO;
      pause_cnt_r    <= PAUSE_ZERO;
    end else begin
      state_r        <= state_nxt_s;
      ball_x_r       <= ball_x_nxt_s;
      ball_y_r       <= ball_y_nxt_s;
      dx_r           <= dx_nxt_s;
      dy_r           <= dy_nxt_s;
      player_pos_r   <= player_pos_nxt_s;
      com_pos_r      <= com_pos_nxt_s;
      player_score_r <= player_score_nxt_s;
      com_score_r    <= com_score_nxt_s;
      ball_cnt_r     <= ball_cnt_nxt_s;
      pad_cnt_r      <= pad_cnt_nxt_s;
      pause_cnt_r    <= pause_cnt_nxt_s;
    end
  end

  assign ballX       = ball_x_r;
  assign ballY       = ball_y_r;
  assign playerPos   = player_pos_r;
  assign comPos      = com_pos_r;
  assign playerScore = player_score_r;
  assign comScore    = com_score_r;
  assign state       = state_r;

endmodule
